// File: rtl/knn_batch_sched_pkg.sv
// Shared types and default sizes for the KNN batch sequencer.
package knn_batch_sched_pkg;

  localparam int TP_W_DEF   = 8;
  localparam int DP_W_DEF   = 10;
  localparam int NB_LAT_DEF = 2;
  localparam int TO_W_DEF   = 12;

  // Sequencer states, 3-bit encoding exposed on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_DIST = 3'd2,
    ST_INS  = 3'd3,
    ST_WAIT = 3'd4,
    ST_VOTE = 3'd5,
    ST_NEXT = 3'd6,
    ST_FIN  = 3'd7
  } state_e;

endpackage

// File: rtl/knn_batch_sched_if.sv
// Bundle of host, distance-unit, neighbour-list and vote-unit signals around
// the KNN batch sequencer.
//
// Handshakes: dist_req and vote_req are held high until the matching ack is
// seen high at a rising edge while the request is high; the request drops in
// the following cycle. Acks arriving while the request is low are ignored.
// nb_clr, nb_ins, res_valid and done are single-cycle pulses with no reply.
interface knn_batch_sched_if
  import knn_batch_sched_pkg::*;
#(
  parameter int TP_W = TP_W_DEF,
  parameter int DP_W = DP_W_DEF
) ();
  logic            start;
  logic [TP_W-1:0] n_test;
  logic [DP_W-1:0] n_data;
  logic            busy;
  logic            done;
  logic [TP_W-1:0] test_idx;
  logic [DP_W-1:0] data_idx;
  logic            dist_req;
  logic            dist_ack;
  logic            nb_clr;
  logic            nb_ins;
  logic            vote_req;
  logic            vote_ack;
  logic            res_valid;
  logic            err;
  state_e          dbg_state;

  // Sequencer side.
  modport master (
    input  start, n_test, n_data, dist_ack, vote_ack,
    output busy, done, test_idx, data_idx, dist_req, nb_clr, nb_ins,
           vote_req, res_valid, err, dbg_state
  );

  // Host and datapath units side.
  modport slave (
    output start, n_test, n_data, dist_ack, vote_ack,
    input  busy, done, test_idx, data_idx, dist_req, nb_clr, nb_ins,
           vote_req, res_valid, err, dbg_state
  );
endinterface

// File: rtl/knn_idx_cnt.sv
// Index counter: synchronous clear, increment, and an at-limit flag.
module knn_idx_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] lim_i,
  output logic [W-1:0] idx_o,
  output logic         last_o
);
  logic [W-1:0] idx_q;

  // Index register; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!rst)       idx_q <= '0;
    else if (clr_i) idx_q <= '0;
    else if (inc_i) idx_q <= idx_q + W'(1);
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == lim_i);
endmodule

// File: rtl/knn_batch_sched.sv
// KNN batch sequencer: walks every (test point, data point) pair, driving
// the distance unit, neighbour list and vote unit in turn.
// Optional watchdog on the DIST/VOTE waits is built when KNN_TIMEOUT_EN is
// defined; otherwise err is tied low and no watchdog flops exist.
module knn_batch_sched
  import knn_batch_sched_pkg::*;
#(
  parameter int TP_W   = TP_W_DEF,
  parameter int DP_W   = DP_W_DEF,
  parameter int NB_LAT = NB_LAT_DEF
`ifdef KNN_TIMEOUT_EN
  , parameter int TO_W = TO_W_DEF
`endif
) (
  input logic               clk,
  input logic               rst,
  knn_batch_sched_if.master bus
);
  localparam int WC_W = (NB_LAT > 1) ? $clog2(NB_LAT) : 1;
  localparam logic [WC_W-1:0] WC_LOAD = WC_W'(NB_LAT - 1);

  state_e          state_q, state_d;
  logic [TP_W-1:0] n_test_q;
  logic [DP_W-1:0] n_data_q;
  logic [WC_W-1:0] wcnt_q;
  logic [TP_W-1:0] test_idx, test_lim;
  logic [DP_W-1:0] data_idx, data_lim;
  logic            test_last, data_last;
  logic            test_clr, test_inc, data_clr, data_inc;
  logic            accept;
  logic            timeout;
  logic            err_o_int;

  assign accept = (state_q == ST_IDLE) && bus.start;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic; ack wins over a same-cycle watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start)
                 state_d = (bus.n_test == '0 || bus.n_data == '0) ? ST_FIN : ST_CLR;
      ST_CLR:  state_d = ST_DIST;
      ST_DIST: if (bus.dist_ack) state_d = ST_INS;
               else if (timeout) state_d = ST_FIN;
      ST_INS:  state_d = ST_WAIT;
      ST_WAIT: if (wcnt_q == '0) state_d = data_last ? ST_VOTE : ST_DIST;
      ST_VOTE: if (bus.vote_ack) state_d = ST_NEXT;
               else if (timeout) state_d = ST_FIN;
      ST_NEXT: state_d = test_last ? ST_FIN : ST_CLR;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded purely from the current state.
  always_comb begin
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_FIN);
    bus.nb_clr    = (state_q == ST_CLR);
    bus.dist_req  = (state_q == ST_DIST);
    bus.nb_ins    = (state_q == ST_INS);
    bus.vote_req  = (state_q == ST_VOTE);
    bus.res_valid = (state_q == ST_NEXT);
    bus.dbg_state = state_q;
  end

  // Latch the batch dimensions when a start is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      n_test_q <= '0;
      n_data_q <= '0;
    end else if (accept) begin
      n_test_q <= bus.n_test;
      n_data_q <= bus.n_data;
    end
  end

  // Neighbour-list settle counter: loaded on insert, counts down in WAIT.
  always_ff @(posedge clk) begin
    if (!rst)                                  wcnt_q <= '0;
    else if (state_q == ST_INS)                wcnt_q <= WC_LOAD;
    else if (state_q == ST_WAIT && wcnt_q != '0) wcnt_q <= wcnt_q - WC_W'(1);
  end

  // Limits are count-1; a zero count never reaches these states.
  assign test_lim = n_test_q - TP_W'(1);
  assign data_lim = n_data_q - DP_W'(1);
  assign test_clr = (state_q == ST_FIN);
  assign test_inc = (state_q == ST_NEXT) && !test_last;
  assign data_clr = (state_q == ST_NEXT) || (state_q == ST_FIN);
  assign data_inc = (state_q == ST_WAIT) && (wcnt_q == '0) && !data_last;

  knn_idx_cnt #(.W(TP_W)) u_test_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (test_clr),
    .inc_i  (test_inc),
    .lim_i  (test_lim),
    .idx_o  (test_idx),
    .last_o (test_last)
  );

  knn_idx_cnt #(.W(DP_W)) u_data_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (data_clr),
    .inc_i  (data_inc),
    .lim_i  (data_lim),
    .idx_o  (data_idx),
    .last_o (data_last)
  );

  assign bus.test_idx = test_idx;
  assign bus.data_idx = data_idx;

`ifdef KNN_TIMEOUT_EN
  localparam logic [TO_W-1:0] WD_LAST = {TO_W{1'b1}} - TO_W'(1);
  logic [TO_W-1:0] wd_q;
  logic            err_q;
  logic            waiting;

  assign waiting = (state_q == ST_DIST && !bus.dist_ack) ||
                   (state_q == ST_VOTE && !bus.vote_ack);
  // Expires on the (2^TO_W-1)th unanswered cycle of a single wait.
  assign timeout = waiting && (wd_q == WD_LAST);

  // Watchdog: counts consecutive unanswered DIST/VOTE cycles.
  always_ff @(posedge clk) begin
    if (!rst)         wd_q <= '0;
    else if (waiting) wd_q <= wd_q + TO_W'(1);
    else              wd_q <= '0;
  end

  // Sticky error flag, cleared by reset or the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst)         err_q <= 1'b0;
    else if (accept)  err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign err_o_int = err_q;
`else
  assign timeout   = 1'b0;
  assign err_o_int = 1'b0;
`endif

  assign bus.err = err_o_int;
endmodule
